// File: rtl/lzss_stream_ctrl.sv
// LZSS front-end: stages 32-bit host words, unpacks them into a byte look-ahead
// window, offers it to the match datapath and retires consumed bytes.
module lzss_stream_ctrl #(
  parameter int LA_DEPTH = 5,
  parameter int CW_W     = 11,
  parameter int CNT_W    = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           data,
  input  logic                  data_valid,
  input  logic                  drop_done,
  output logic                  busy,
  output logic [8*LA_DEPTH-1:0] la_data,
  output logic [2:0]            la_len,
  output logic                  la_valid,
  input  logic                  consume_valid,
  input  logic [2:0]            consume_len,
  input  logic [CW_W-1:0]       cw_in,
  output logic [CW_W-1:0]       codeword,
  output logic [CNT_W-1:0]      enc_num,
  output logic                  out_valid,
  output logic                  finish
);

  typedef enum logic [1:0] {IDLE, FILL, OFFER, DONE} state_e;

  localparam logic [2:0] LA_D3 = 3'(LA_DEPTH);
  localparam int         WW    = 8*LA_DEPTH;

  state_e              state_q, state_d;
  logic [31:0]         word_buf_q, word_buf_d;
  logic [2:0]          word_len_q, word_len_d;
  logic                drop_seen_q, drop_seen_d;
  logic [WW-1:0]       win_q, win_d;
  logic [2:0]          win_len_q, win_len_d;
  logic                busy_q, busy_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic [CNT_W-1:0]    enc_q, enc_d;
  logic                ov_q, ov_d;

  logic                host_take, drop_take, cons_ok;
  logic [2:0]          room, n, post_len, post_wl;
  logic [31:0]         mask;
  logic [WW+31:0]      ins;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_buf_q  <= '0;
      word_len_q  <= '0;
      drop_seen_q <= 1'b0;
      win_q       <= '0;
      win_len_q   <= '0;
      busy_q      <= 1'b1;
      cw_q        <= '0;
      enc_q       <= '0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_buf_q  <= word_buf_d;
      word_len_q  <= word_len_d;
      drop_seen_q <= drop_seen_d;
      win_q       <= win_d;
      win_len_q   <= win_len_d;
      busy_q      <= busy_d;
      cw_q        <= cw_d;
      enc_q       <= enc_d;
      ov_q        <= ov_d;
    end
  end

  // Transfer size and consume legality, shared by next-state and datapath.
  always_comb begin
    host_take = !busy_q && data_valid;
    drop_take = !busy_q && drop_done;
    room      = LA_D3 - win_len_q;
    n         = '0;
    if (state_q == FILL) n = (room < word_len_q) ? room : word_len_q;
    post_len  = win_len_q + n;
    post_wl   = word_len_q - n;
    cons_ok   = (state_q == OFFER) && consume_valid && (consume_len != 3'd0) &&
                (consume_len <= win_len_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FILL;
      FILL: begin
        if (post_len == LA_D3)                                      state_d = OFFER;
        else if (drop_seen_q && post_wl == 3'd0 && post_len != 3'd0) state_d = OFFER;
        else if (drop_seen_q && word_len_q == 3'd0 && win_len_q == 3'd0) state_d = DONE;
      end
      OFFER: if (cons_ok) state_d = FILL;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state. Capture only happens with an empty staging register,
  // so it never collides with a FILL transfer.
  always_comb begin
    mask        = (n >= 3'd4) ? 32'hFFFF_FFFF : ((32'd1 << {n, 3'b000}) - 32'd1);
    ins         = {{WW{1'b0}}, word_buf_q & mask} << {win_len_q, 3'b000};
    word_buf_d  = word_buf_q >> {n, 3'b000};
    word_len_d  = post_wl;
    if (host_take) begin
      word_buf_d = data;
      word_len_d = 3'd4;
    end
    drop_seen_d = drop_seen_q | drop_take;
    win_d       = win_q;
    win_len_d   = win_len_q;
    cw_d        = cw_q;
    enc_d       = enc_q;
    ov_d        = 1'b0;
    if (state_q == FILL) begin
      win_d     = win_q | ins[WW-1:0];
      win_len_d = post_len;
    end
    if (cons_ok) begin
      win_d     = win_q >> {consume_len, 3'b000};
      win_len_d = win_len_q - consume_len;
      cw_d      = cw_in;
      ov_d      = 1'b1;
      if (enc_q != '1) enc_d = enc_q + 1'b1;
    end
  end

  always_comb begin
    busy_d   = (state_d == IDLE) || (state_d == DONE) || (word_len_d != 3'd0) || drop_seen_d;
    la_valid = (state_q == OFFER);
    finish   = (state_q == DONE);
  end

  assign busy      = busy_q;
  assign la_data   = win_q;
  assign la_len    = win_len_q;
  assign codeword  = cw_q;
  assign enc_num   = enc_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_lzss_stream_ctrl.sv
// Bench for lzss_stream_ctrl: directed scenarios plus a long random stream,
// all checked every cycle against a byte-queue reference model.
module tb_lzss_stream_ctrl;
  localparam int LA = 5;
  localparam int M_IDLE = 0, M_FILL = 1, M_OFFER = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic        data_valid, drop_done, consume_valid;
  logic [2:0]  consume_len;
  logic [10:0] cw_in;
  logic        busy, la_valid, out_valid, finish;
  logic [39:0] la_data;
  logic [2:0]  la_len;
  logic [10:0] codeword;
  logic [11:0] enc_num;

  lzss_stream_ctrl dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .drop_done(drop_done), .busy(busy), .la_data(la_data), .la_len(la_len),
    .la_valid(la_valid), .consume_valid(consume_valid), .consume_len(consume_len),
    .cw_in(cw_in), .codeword(codeword), .enc_num(enc_num),
    .out_valid(out_valid), .finish(finish)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: staged bytes and window bytes as queues, oldest first.
  logic [7:0]  stg[$];
  logic [7:0]  win[$];
  int          m_phase;
  bit          m_drop, m_busy, m_ov;
  int          m_enc;
  logic [10:0] m_cw;

  function automatic void m_reset();
    stg.delete(); win.delete();
    m_phase = M_IDLE; m_drop = 0; m_busy = 1; m_ov = 0; m_enc = 0; m_cw = '0;
  endfunction

  function automatic void m_edge();
    bit take, dtake, was_drop, was_empty;
    take      = !m_busy && data_valid;
    dtake     = !m_busy && drop_done;
    was_drop  = m_drop;
    was_empty = (stg.size() == 0) && (win.size() == 0);
    m_ov      = 0;
    case (m_phase)
      M_IDLE: m_phase = M_FILL;
      M_FILL: begin
        while (win.size() < LA && stg.size() > 0) win.push_back(stg.pop_front());
        if (win.size() == LA) m_phase = M_OFFER;
        else if (was_drop && stg.size() == 0 && win.size() > 0) m_phase = M_OFFER;
        else if (was_drop && was_empty) m_phase = M_DONE;
      end
      M_OFFER: begin
        if (consume_valid && consume_len >= 1 && int'(consume_len) <= win.size()) begin
          repeat (int'(consume_len)) void'(win.pop_front());
          m_cw = cw_in; m_ov = 1;
          if (m_enc < 4095) m_enc++;
          m_phase = M_FILL;
        end
      end
      default: ;
    endcase
    if (take) for (int i = 0; i < 4; i++) stg.push_back(data[8*i +: 8]);
    if (dtake) m_drop = 1;
    m_busy = (m_phase == M_IDLE) || (m_phase == M_DONE) || (stg.size() != 0) || m_drop;
  endfunction

  function automatic logic [39:0] exp_la_data();
    logic [39:0] r = '0;
    for (int i = 0; i < win.size(); i++) r[8*i +: 8] = win[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy",      64'(busy),      64'(m_busy));
    chk("la_valid",  64'(la_valid),  64'(m_phase == M_OFFER));
    chk("la_len",    64'(la_len),    64'(win.size()));
    chk("la_data",   64'(la_data),   64'(exp_la_data()));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("codeword",  64'(codeword),  64'(m_cw));
    chk("enc_num",   64'(enc_num),   64'(m_enc));
    chk("finish",    64'(finish),    64'(m_phase == M_DONE));
  endtask

  task automatic step(input bit dv, input logic [31:0] d, input bit dd,
                      input bit cv, input logic [2:0] cl, input logic [10:0] cw);
    data_valid = dv; data = d; drop_done = dd;
    consume_valid = cv; consume_len = cl; cw_in = cw;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 3'd0, 11'h0);
  endtask

  // Reset lands between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 reset = 1'b1;
    m_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout n_assert=%0d", n_assert);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data = '0; data_valid = 0; drop_done = 0;
    consume_valid = 0; consume_len = '0; cw_in = '0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_la_data", 64'(la_data), 64'd0);
    reset = 1'b0;

    // Two words fill the window; junk while busy must be ignored.
    idle();
    chk("s1_busy_low", 64'(busy), 64'd0);
    step(1, 32'h44332211, 0, 0, 3'd0, 11'h0);
    step(1, 32'hDEADBEEF, 0, 0, 3'd0, 11'h0);
    step(1, 32'h88776655, 0, 0, 3'd0, 11'h0);
    idle();
    chk("s1_la_valid", 64'(la_valid), 64'd1);
    chk("s1_la_data", 64'(la_data), 64'h55_4433_2211);
    chk("s1_la_len", 64'(la_len), 64'd5);
    chk("s1_busy", 64'(busy), 64'd1);

    // Illegal consume lengths are ignored.
    step(0, 32'h0, 0, 1, 3'd0, 11'h7FF);
    chk("s5_ov0", 64'(out_valid), 64'd0);
    step(0, 32'h0, 0, 1, 3'd6, 11'h7FF);
    chk("s5_ov6", 64'(out_valid), 64'd0);
    chk("s5_data", 64'(la_data), 64'h55_4433_2211);
    chk("s5_enc", 64'(enc_num), 64'd0);

    // Consume three bytes; the staged remainder refills the window.
    step(0, 32'h0, 0, 1, 3'd3, 11'h123);
    chk("s2_ov", 64'(out_valid), 64'd1);
    chk("s2_cw", 64'(codeword), 64'h123);
    chk("s2_enc", 64'(enc_num), 64'd1);
    idle();
    chk("s2_data", 64'(la_data), 64'h88_7766_5544);
    chk("s2_busy", 64'(busy), 64'd0);
    chk("s2_ov_drop", 64'(out_valid), 64'd0);

    // Walk to OFFER with la_len=3, enc_num=7, then reset asynchronously.
    step(1, 32'hCCBBAA99, 0, 0, 3'd0, 11'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 32'h0, 0, 1, 3'd1, 11'(k)); idle();
    end
    step(0, 32'h0, 1, 0, 3'd0, 11'h0);
    for (int k = 0; k < 2; k++) begin
      step(0, 32'h0, 0, 1, 3'd1, 11'h40); idle();
    end
    chk("s6_len", 64'(la_len), 64'd3);
    chk("s6_enc", 64'(enc_num), 64'd7);
    do_reset();
    chk("s6_rst_enc", 64'(enc_num), 64'd0);
    chk("s6_rst_busy", 64'(busy), 64'd1);
    idle();
    step(1, $urandom, 0, 0, 3'd0, 11'h0); idle();
    step(1, $urandom, 0, 0, 3'd0, 11'h0); idle();
    step(0, 32'h0, 0, 1, 3'd2, 11'h2A);
    chk("s6_restart_enc", 64'(enc_num), 64'd1);

    // Single word with drop_done in the same cycle.
    do_reset();
    idle();
    step(1, 32'hDDCCBBAA, 1, 0, 3'd0, 11'h0);
    idle();
    chk("s3_data", 64'(la_data), 64'hDD_CCBB_AA);
    chk("s3_len", 64'(la_len), 64'd4);
    step(0, 32'h0, 0, 1, 3'd4, 11'h055);
    chk("s3_enc", 64'(enc_num), 64'd1);
    chk("s3_fin0", 64'(finish), 64'd0);
    idle();
    chk("s3_fin", 64'(finish), 64'd1);
    step(0, 32'h0, 0, 1, 3'd1, 11'h1);
    chk("s3_done_ov", 64'(out_valid), 64'd0);
    chk("s3_busy", 64'(busy), 64'd1);

    // drop_done with no data at all.
    do_reset();
    idle();
    step(0, 32'h0, 1, 0, 3'd0, 11'h0);
    idle();
    chk("s4_fin", 64'(finish), 64'd1);
    chk("s4_enc", 64'(enc_num), 64'd0);

    // Long random stream: enc_num saturates, then drop and drain.
    do_reset();
    idle();
    for (int c = 0; c < 30000; c++) begin
      step($urandom_range(0, 3) != 0, $urandom,
           (c > 28000) && ($urandom_range(0, 7) == 0),
           $urandom_range(0, 7) != 0,
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1,
           11'($urandom));
      if (m_phase == M_DONE) break;
    end
    chk("rnd_sat", 64'(enc_num), 64'hFFF);
    for (int c = 0; c < 200 && m_phase != M_DONE; c++)
      step(0, 32'h0, 1, 1, 3'd1, 11'($urandom));
    chk("rnd_finish", 64'(finish), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
